mem_bus_arbiter: RTL
====================

Name: mem_bus_arbiter

Overview:
- Shares the core's single memory bus between instruction fetch (IF) and the EX-stage load/store port.
- Arbitrates with a data-first, starvation-free policy and runs one outstanding transaction at a time.
- Converts EX byte/half/word stores into lane-aligned write data plus byte enables, and flags misaligned accesses.
- Provides per-requester grant, response and stall signals to the pipeline control.

Parameters:
AW, 32, address width (matches the EX memory address bus)
DW, 32, data width (fixed at 32; the byte-lane logic assumes 4 lanes)
TIMEOUT, 255, max cycles to wait for bus_ack before aborting (>=2)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, synchronous and active-high
if_req  in  1  IF read request; held until if_gnt
if_addr  in  AW  IF word address
if_gnt  out  1  IF request accepted (1-cycle pulse)
if_rvalid  out  1  IF response valid (1-cycle pulse)
if_rdata  out  DW  IF read data, valid with if_rvalid
ex_req  in  1  EX load/store request; held until ex_gnt
ex_we  in  1  1 = store, 0 = load
ex_size  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal
ex_addr  in  AW  EX byte address
ex_wdata  in  DW  store data, zero-extended in the low bits
ex_gnt  out  1  EX request accepted (1-cycle pulse)
ex_rvalid  out  1  EX done (load data or store completion), 1-cycle pulse
ex_rdata  out  DW  raw bus word for loads; 0 for stores
ex_err  out  1  misaligned/illegal size or timeout, 1-cycle pulse
stall_if  out  1  ex: if_req & ~if_rvalid
stall_ex  out  1  ex_req | (state==BUS_EX), cleared in the ex_rvalid/ex_err cycle
bus_req  out  1  bus transaction valid
bus_we  out  1  bus write
bus_addr  out  AW  bus address (EX: {addr[AW-1:2],2'b00}; IF: if_addr)
bus_be  out  4  byte enables
bus_wdata  out  DW  lane-aligned write data
bus_ack  in  1  bus completes the transaction this cycle
bus_rdata  in  DW  read data, valid with bus_ack

Behaviour:
- Reset (sync, active-high): state = IDLE; counter = 0; last_ex = 0.
  - All outputs 0: gnt, rvalid, err, bus_req, bus_we, bus_be, bus_addr, bus_wdata, rdata.
- Reset mid-transaction: returns to IDLE at that edge and drops bus_req the next cycle; a bus_ack arriving afterwards is ignored.
- States: IDLE, BUS_IF, BUS_EX, ERR.
- IDLE arbitration, registered:
  - ex_req only -> EX selected.
  - if_req only -> IF selected.
  - Both, last_ex = 0 -> EX selected.
  - Both, last_ex = 1 -> IF selected.
  - The winner's gnt pulses in this IDLE cycle; its request fields are latched at the edge.
  - last_ex <= (EX selected) on every grant.
- EX alignment check at grant:
  - half with addr[0] = 1, word with addr[1:0] != 0, or size = 11 -> ERR.
  - ERR: no bus access; ex_err pulses in the ERR cycle, then IDLE.
- BUS_x outputs: bus_req = 1 with the latched fields held stable until bus_ack.
  - IF: bus_we = 0, bus_be = 1111.
  - EX byte: be = 0001 << a[1:0]; wdata = wdata << 8*a[1:0].
  - EX half: be = 0011 << 2*a[1]; wdata = wdata << 16*a[1].
  - EX word: be = 1111.
  - EX load: bus_we = 0, be computed as above.
- Completion: bus_ack seen in BUS_x -> bus_req drops and rvalid/rdata are registered, appearing the next cycle (state IDLE).
  - Minimum latency, req to rvalid: 3 cycles (grant, bus cycle with immediate ack, response).
  - A new grant may occur in the same IDLE cycle that presents rvalid.
- Timeout: counter clears on entry to BUS_x and increments each cycle without bus_ack.
  - Reaching TIMEOUT-1 -> abort: bus_req drops, the requester's err pulses next cycle, no rvalid, state IDLE.
  - IF timeout also uses ex_err? No: IF timeout re-arbitrates silently; only EX raises ex_err.
- bus_ack outside BUS_x is ignored.
- if_rdata/ex_rdata hold their last value between pulses; ex_rdata = 0 after a store.

Test Plan:
- Reset with if_req = 1 held -> all outputs 0 during reset; if_gnt pulses in the first cycle after rst falls.
- IF read 0x100, bus_ack 1 cycle after bus_req with rdata 0xDEADBEEF -> bus_be = 1111, if_rvalid one cycle later with 0xDEADBEEF.
- Simultaneous ex_req/if_req on 3 consecutive transactions -> grant order EX, IF, EX; no requester waits more than one transaction.
- SB addr 0x203 data 0x000000A5 -> bus_addr 0x200, be 1000, wdata 0xA5000000, bus_we 1. SH addr 0x202 data 0x1234 -> be 1100, wdata 0x12340000.
- LW addr 0x102 -> no bus_req, ex_err pulse, stall_ex clears. SH addr 0x201 -> same.
- TIMEOUT = 4, bus_ack never asserted on an EX load -> bus_req high 4 cycles then ex_err; a later IF request is served normally. Reset asserted mid-BUS_EX -> bus_req 0 next cycle, late ack produces no rvalid.

Source files
------------

// File: rtl/mem_bus_arbiter_if.sv
// Shared memory bus between the IF/EX arbiter (master) and the memory fabric (slave).
// One transaction at a time: bus_req stays high with stable fields until bus_ack.
interface mem_bus_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          bus_req;
  logic          bus_we;
  logic [AW-1:0] bus_addr;
  logic [3:0]    bus_be;
  logic [DW-1:0] bus_wdata;
  logic          bus_ack;
  logic [DW-1:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Arbitrates the single memory bus between instruction fetch and the EX load/store port.
// Data-first with alternation on contention, lane-aligned stores, misalignment and timeout errors.
module mem_bus_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          ex_req,
  input  logic          ex_we,
  input  logic [1:0]    ex_size,
  input  logic [AW-1:0] ex_addr,
  input  logic [DW-1:0] ex_wdata,
  output logic          ex_gnt,
  output logic          ex_rvalid,
  output logic [DW-1:0] ex_rdata,
  output logic          ex_err,
  output logic          stall_if,
  output logic          stall_ex,
  mem_bus_arbiter_if.master bus
);
  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, BUS_IF, BUS_EX, ERR} state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          last_ex_reg;
  logic          lat_we_reg;
  logic [AW-1:0] lat_addr_reg;
  logic [3:0]    lat_be_reg;
  logic [DW-1:0] lat_wdata_reg;
  logic          if_rvalid_reg;
  logic          ex_rvalid_reg;
  logic          ex_timeout_reg;
  logic [DW-1:0] if_rdata_reg;
  logic [DW-1:0] ex_rdata_reg;

  logic          grant;
  logic          sel_ex;
  logic          ex_misaligned;
  logic [3:0]    align_be;
  logic [DW-1:0] align_wdata;
  logic          bus_active;
  logic          timeout_hit;

  assign bus_active  = (state_reg == BUS_IF) || (state_reg == BUS_EX);
  assign timeout_hit = (cnt_reg == CW'(TIMEOUT - 1));

  // Store data arrives right-justified; move it onto the lanes selected by the byte address.
  always_comb begin
    align_be      = 4'b0000;
    align_wdata   = '0;
    ex_misaligned = 1'b0;
    case (ex_size)
      2'b00: begin
        align_be    = 4'b0001 << ex_addr[1:0];
        align_wdata = ex_wdata << {ex_addr[1:0], 3'b000};
      end
      2'b01: begin
        align_be      = 4'b0011 << {ex_addr[1], 1'b0};
        align_wdata   = ex_wdata << {ex_addr[1], 4'b0000};
        ex_misaligned = ex_addr[0];
      end
      2'b10: begin
        align_be      = 4'b1111;
        align_wdata   = ex_wdata;
        ex_misaligned = |ex_addr[1:0];
      end
      default: ex_misaligned = 1'b1;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    grant      = 1'b0;
    sel_ex     = 1'b0;
    case (state_reg)
      IDLE: begin
        cnt_next = '0;
        // Gated by rst so no grant escapes while the block is held in reset.
        if (!rst && (if_req || ex_req)) begin
          grant  = 1'b1;
          sel_ex = ex_req && (!if_req || !last_ex_reg);
          if (sel_ex) begin
            state_next = ex_misaligned ? ERR : BUS_EX;
          end else begin
            state_next = BUS_IF;
          end
        end
      end
      BUS_IF, BUS_EX: begin
        if (bus.bus_ack || timeout_hit) begin
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      ERR:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      last_ex_reg    <= 1'b0;
      lat_we_reg     <= 1'b0;
      lat_addr_reg   <= '0;
      lat_be_reg     <= 4'b0000;
      lat_wdata_reg  <= '0;
      if_rvalid_reg  <= 1'b0;
      ex_rvalid_reg  <= 1'b0;
      ex_timeout_reg <= 1'b0;
      if_rdata_reg   <= '0;
      ex_rdata_reg   <= '0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      if_rvalid_reg  <= 1'b0;
      ex_rvalid_reg  <= 1'b0;
      ex_timeout_reg <= 1'b0;
      if (grant) begin
        last_ex_reg <= sel_ex;
        if (sel_ex) begin
          lat_we_reg    <= ex_we;
          lat_addr_reg  <= {ex_addr[AW-1:2], 2'b00};
          lat_be_reg    <= align_be;
          lat_wdata_reg <= ex_we ? align_wdata : '0;
        end else begin
          lat_we_reg    <= 1'b0;
          lat_addr_reg  <= if_addr;
          lat_be_reg    <= 4'b1111;
          lat_wdata_reg <= '0;
        end
      end
      if (state_reg == BUS_IF && bus.bus_ack) begin
        if_rvalid_reg <= 1'b1;
        if_rdata_reg  <= bus.bus_rdata;
      end
      if (state_reg == BUS_EX) begin
        if (bus.bus_ack) begin
          ex_rvalid_reg <= 1'b1;
          ex_rdata_reg  <= lat_we_reg ? '0 : bus.bus_rdata;
        end else if (timeout_hit) begin
          ex_timeout_reg <= 1'b1;
        end
      end
    end
  end

  assign if_gnt    = grant && !sel_ex;
  assign ex_gnt    = grant && sel_ex;
  assign if_rvalid = if_rvalid_reg;
  assign if_rdata  = if_rdata_reg;
  assign ex_rvalid = ex_rvalid_reg;
  assign ex_rdata  = ex_rdata_reg;
  assign ex_err    = (state_reg == ERR) || ex_timeout_reg;
  assign stall_if  = if_req && !if_rvalid;
  assign stall_ex  = (ex_req || state_reg == BUS_EX) && !ex_rvalid && !ex_err;

  // Bus fields read as zero outside a transaction.
  assign bus.bus_req   = bus_active;
  assign bus.bus_we    = bus_active && lat_we_reg;
  assign bus.bus_addr  = bus_active ? lat_addr_reg : '0;
  assign bus.bus_be    = bus_active ? lat_be_reg : 4'b0000;
  assign bus.bus_wdata = bus_active ? lat_wdata_reg : '0;
endmodule
